shot_sequencer: RTL and testbench

Turn-level controller that sequences the billiard ball datapath: waits for the table to settle, lets the player charge a shot, computes and writes the cue-ball velocity, then supervises the roll until every ball stops or a timeout forces a halt. Sits between the player-input logic and the ball datapath instances. Drives the cue ball's velocity write port and a table-wide halt request. Reports turn status to the display and scoring logic.

---
 rtl/shot_sequencer_if.sv | 33 +++
 rtl/shot_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_shot_sequencer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/shot_sequencer_if.sv
// Turn-control bundle between the player/datapath side and the shot sequencer.
interface shot_sequencer_if #(
   parameter int NUM_BALLS = 4
);
   logic                 startOfFrame;
   logic                 shootHeld;
   logic signed [7:0]    aimDirX;
   logic signed [7:0]    aimDirY;
   logic [NUM_BALLS-1:0] ballStopped;
   logic                 cueVelocityWriteEnable;
   logic signed [10:0]   cueVelocityX;
   logic signed [10:0]   cueVelocityY;
   logic                 haltRequest;
   logic                 aimReady;
   logic [7:0]           powerLevel;
   logic                 turnDone;
   logic [7:0]           turnCount;
   logic                 timeoutFlag;

   // Player input / ball datapath side
   modport master (
      output startOfFrame, shootHeld, aimDirX, aimDirY, ballStopped,
      input  cueVelocityWriteEnable, cueVelocityX, cueVelocityY, haltRequest,
             aimReady, powerLevel, turnDone, turnCount, timeoutFlag
   );

   // Sequencer side
   modport slave (
      input  startOfFrame, shootHeld, aimDirX, aimDirY, ballStopped,
      output cueVelocityWriteEnable, cueVelocityX, cueVelocityY, haltRequest,
             aimReady, powerLevel, turnDone, turnCount, timeoutFlag
   );
endinterface

// File: rtl/shot_sequencer.sv
// Turn-level controller: settle, aim, charge, strike, supervise roll, halt on timeout.
module shot_sequencer #(
   parameter int NUM_BALLS             = 4,
   parameter int POWER_MAX             = 200,
   parameter int POWER_STEP            = 4,
   parameter int SETTLE_FRAMES         = 8,
   parameter int MOTION_WAIT_FRAMES    = 4,
   parameter int MOTION_TIMEOUT_FRAMES = 1800
) (
   input logic             clk,
   input logic             resetN,
   shot_sequencer_if.slave bus
);
   localparam int SW = $clog2(SETTLE_FRAMES + 1);
   localparam int WW = $clog2(MOTION_WAIT_FRAMES + 1);
   localparam int MW = $clog2(MOTION_TIMEOUT_FRAMES + 1);
   localparam logic [NUM_BALLS-1:0] ALL_STOPPED = '1;

   typedef enum logic [2:0] {
      SETTLE, AIM, CHARGE, STRIKE, WAIT_MOTION, MOVING, HALT
   } state_t;

   state_t             state, state_nx;
   logic [SW-1:0]      settle_cnt, settle_nx;
   logic [WW-1:0]      wait_cnt, wait_nx;
   logic [MW-1:0]      move_cnt, move_nx;
   logic               saw_release, saw_release_nx;
   logic [7:0]         power, power_nx;
   logic signed [10:0] vel_x, vel_x_nx;
   logic signed [10:0] vel_y, vel_y_nx;
   logic               turn_done, turn_done_nx;
   logic [7:0]         turn_count, turn_count_nx;
   logic               timeout_flag, timeout_nx;
   logic               turn_end;

   logic       frame;
   logic       all_stopped;
   logic [8:0] power_sum;

   assign frame       = bus.startOfFrame;
   assign all_stopped = (bus.ballStopped == ALL_STOPPED);
   assign power_sum   = {1'b0, power} + 9'(POWER_STEP);

   // Clamp aim to +/-64, scale by power, floor-divide by 64.
   function automatic logic signed [10:0] strike_vel(input logic signed [7:0] aim,
                                                     input logic [7:0]        pwr);
      logic signed [7:0]  clamped;
      logic signed [16:0] prod;
      if (aim > 8'sd64)       clamped = 8'sd64;
      else if (aim < -8'sd64) clamped = -8'sd64;
      else                    clamped = aim;
      prod = $signed({{9{clamped[7]}}, clamped}) * $signed({9'b0, pwr});
      return 11'(prod >>> 6);
   endfunction

   // State and datapath registers
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state        <= SETTLE;
         settle_cnt   <= '0;
         wait_cnt     <= '0;
         move_cnt     <= '0;
         saw_release  <= 1'b0;
         power        <= '0;
         vel_x        <= '0;
         vel_y        <= '0;
         turn_done    <= 1'b0;
         turn_count   <= '0;
         timeout_flag <= 1'b0;
      end else begin
         state        <= state_nx;
         settle_cnt   <= settle_nx;
         wait_cnt     <= wait_nx;
         move_cnt     <= move_nx;
         saw_release  <= saw_release_nx;
         power        <= power_nx;
         vel_x        <= vel_x_nx;
         vel_y        <= vel_y_nx;
         turn_done    <= turn_done_nx;
         turn_count   <= turn_count_nx;
         timeout_flag <= timeout_nx;
      end
   end

   // Next-state and next-register values; frame-gated except STRIKE and HALT
   always_comb begin
      state_nx       = state;
      settle_nx      = settle_cnt;
      wait_nx        = wait_cnt;
      move_nx        = move_cnt;
      saw_release_nx = saw_release;
      power_nx       = power;
      vel_x_nx       = vel_x;
      vel_y_nx       = vel_y;
      turn_done_nx   = 1'b0;
      turn_count_nx  = turn_count;
      timeout_nx     = timeout_flag;
      turn_end       = 1'b0;

      case (state)
         SETTLE: if (frame) begin
            if (!all_stopped) begin
               settle_nx = '0;
            end else if (settle_cnt == SW'(SETTLE_FRAMES - 1)) begin
               settle_nx      = '0;
               saw_release_nx = 1'b0;
               state_nx       = AIM;
            end else begin
               settle_nx = settle_cnt + SW'(1);
            end
         end
         AIM: if (frame) begin
            if (!all_stopped) begin
               settle_nx = '0;
               state_nx  = SETTLE;
            end else if (bus.shootHeld && saw_release) begin
               power_nx = '0;
               state_nx = CHARGE;
            end else if (!bus.shootHeld) begin
               saw_release_nx = 1'b1;
            end
         end
         CHARGE: if (frame) begin
            if (bus.shootHeld) begin
               power_nx = (power_sum > 9'(POWER_MAX)) ? 8'(POWER_MAX) : power_sum[7:0];
            end else if (power != '0) begin
               vel_x_nx = strike_vel(bus.aimDirX, power);
               vel_y_nx = strike_vel(bus.aimDirY, power);
               state_nx = STRIKE;
            end else begin
               saw_release_nx = 1'b0;
               state_nx       = AIM;
            end
         end
         STRIKE: begin
            timeout_nx = 1'b0;
            wait_nx    = '0;
            state_nx   = WAIT_MOTION;
         end
         WAIT_MOTION: if (frame) begin
            if (!bus.ballStopped[0]) begin
               move_nx  = '0;
               state_nx = MOVING;
            end else if (wait_cnt == WW'(MOTION_WAIT_FRAMES - 1)) begin
               turn_end = 1'b1;
            end else begin
               wait_nx = wait_cnt + WW'(1);
            end
         end
         MOVING: if (frame) begin
            if (all_stopped) begin
               turn_end = 1'b1;
            end else if (move_cnt == MW'(MOTION_TIMEOUT_FRAMES - 1)) begin
               state_nx = HALT;
            end else begin
               move_nx = move_cnt + MW'(1);
            end
         end
         HALT: begin
            timeout_nx = 1'b1;
            turn_end   = 1'b1;
         end
         default: state_nx = SETTLE;
      endcase

      // Turn end is folded into the transition into SETTLE; turnDone is registered
      // so it lands one cycle after the deciding frame or the HALT cycle.
      if (turn_end) begin
         state_nx      = SETTLE;
         settle_nx     = '0;
         power_nx      = '0;
         turn_done_nx  = 1'b1;
         turn_count_nx = turn_count + 8'd1;
      end
   end

   assign bus.cueVelocityWriteEnable = (state == STRIKE);
   assign bus.haltRequest            = (state == HALT);
   assign bus.aimReady               = (state == AIM) || (state == CHARGE);
   assign bus.cueVelocityX           = vel_x;
   assign bus.cueVelocityY           = vel_y;
   assign bus.powerLevel             = power;
   assign bus.turnDone               = turn_done;
   assign bus.turnCount              = turn_count;
   assign bus.timeoutFlag            = timeout_flag;
endmodule

// File: tb/tb_shot_sequencer.sv
// Bench for shot_sequencer: directed turn script with randomized aim/charge/roll
// against a frame-level arithmetic model of the turn rules.
module tb_shot_sequencer;
   localparam int         NB  = 4;
   localparam logic [3:0] ALL = 4'b1111;

   logic clk = 1'b0;
   logic resetN;
   always #5 clk = ~clk;

   shot_sequencer_if #(.NUM_BALLS(NB)) bus_if ();

   shot_sequencer #(
      .NUM_BALLS(NB), .POWER_MAX(200), .POWER_STEP(4), .SETTLE_FRAMES(8),
      .MOTION_WAIT_FRAMES(4), .MOTION_TIMEOUT_FRAMES(1800)
   ) dut (
      .clk(clk), .resetN(resetN), .bus(bus_if)
   );

   int checks = 0, errors = 0;
   int cyc = 0;
   int we_cnt = 0, we_cyc = -1, we_vx = 0, we_vy = 0;
   int halt_cnt = 0, halt_cyc = -1, done_cnt = 0, done_cyc = -1, viol_cnt = 0;

   int exp_turns = 0, exp_we = 0, exp_halt = 0, exp_done = 0;
   int exp_vx = 0, exp_vy = 0, exp_pwr = 0, exp_timeout = 0;
   int fc = 0;

   // Cycle counter
   always @(posedge clk) cyc <= cyc + 1;

   // Pulse recorder, sampled mid-cycle
   always @(negedge clk) begin
      if (bus_if.cueVelocityWriteEnable) begin
         we_cnt <= we_cnt + 1;
         we_cyc <= cyc;
         we_vx  <= int'(bus_if.cueVelocityX);
         we_vy  <= int'(bus_if.cueVelocityY);
      end
      if (bus_if.haltRequest) begin
         halt_cnt <= halt_cnt + 1;
         halt_cyc <= cyc;
      end
      if (bus_if.turnDone) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
      if ((bus_if.haltRequest && bus_if.turnDone) ||
          (bus_if.cueVelocityWriteEnable && bus_if.startOfFrame))
         viol_cnt <= viol_cnt + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   function automatic int ref_vel(input int aim, input int pwr);
      int c, p;
      c = (aim > 64) ? 64 : ((aim < -64) ? -64 : aim);
      p = c * pwr;
      if (p >= 0) return p / 64;
      return -((-p + 63) / 64);
   endfunction

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic frame(input logic held, input logic [3:0] stopped);
      bus_if.shootHeld    = held;
      bus_if.ballStopped  = stopped;
      bus_if.startOfFrame = 1'b1;
      fc = cyc;
      @(posedge clk); #1 bus_if.startOfFrame = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
   endtask

   task automatic settle_to_aim(input logic held);
      repeat (7) frame(held, ALL);
      chk("settle_not_yet", int'(bus_if.aimReady), 0);
      frame(held, ALL);
      chk("settle_aim", int'(bus_if.aimReady), 1);
   endtask

   task automatic arm();
      frame(1'b0, ALL);
      frame(1'b1, ALL);
      chk("charge_entry_power", int'(bus_if.powerLevel), 0);
      chk("charge_aimready", int'(bus_if.aimReady), 1);
   endtask

   task automatic charge(input int n);
      repeat (n) frame(1'b1, ALL);
      exp_pwr = (n * 4 > 200) ? 200 : n * 4;
      chk("charge_power", int'(bus_if.powerLevel), exp_pwr);
   endtask

   task automatic release_shot(input int ax, input int ay);
      bus_if.aimDirX = 8'(ax);
      bus_if.aimDirY = 8'(ay);
      frame(1'b0, ALL);
      if (exp_pwr != 0) begin
         exp_we++;
         exp_vx = ref_vel(ax, exp_pwr);
         exp_vy = ref_vel(ay, exp_pwr);
         exp_timeout = 0;
         chk("strike_count", we_cnt, exp_we);
         chk("strike_latency", we_cyc, fc + 1);
         chk("strike_vx", we_vx, exp_vx);
         chk("strike_vy", we_vy, exp_vy);
         chk("strike_timeout_clr", int'(bus_if.timeoutFlag), 0);
         chk("strike_aimready", int'(bus_if.aimReady), 0);
      end else begin
         chk("zero_power_no_strike", we_cnt, exp_we);
         chk("zero_power_back_aim", int'(bus_if.aimReady), 1);
      end
   endtask

   task automatic end_turn_checks();
      exp_done++;
      exp_turns = (exp_turns + 1) % 256;
      exp_pwr = 0;
      chk("done_count", done_cnt, exp_done);
      chk("done_latency", done_cyc, fc + 1);
      chk("turn_count", int'(bus_if.turnCount), exp_turns);
      chk("turn_power_clr", int'(bus_if.powerLevel), 0);
      chk("turn_no_halt", halt_cnt, exp_halt);
      chk("vel_hold_x", int'(bus_if.cueVelocityX), exp_vx);
      chk("vel_hold_y", int'(bus_if.cueVelocityY), exp_vy);
      chk("turn_timeout", int'(bus_if.timeoutFlag), exp_timeout);
   endtask

   task automatic roll(input int nmove);
      if (nmove == 0) begin
         repeat (3) frame(1'b0, ALL);
         chk("wait_not_done", done_cnt, exp_done);
         frame(1'b0, ALL);
      end else begin
         frame(1'b0, 4'b1110);
         repeat (nmove - 1) frame(1'b0, 4'($urandom_range(0, 14)));
         chk("moving_not_done", done_cnt, exp_done);
         frame(1'b0, ALL);
      end
      end_turn_checks();
   endtask

   initial begin
      int ax, ay, n, m;
      resetN              = 1'b0;
      bus_if.startOfFrame = 1'b0;
      bus_if.shootHeld    = 1'b0;
      bus_if.aimDirX      = '0;
      bus_if.aimDirY      = '0;
      bus_if.ballStopped  = ALL;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_aimready", int'(bus_if.aimReady), 0);
      chk("rst_power", int'(bus_if.powerLevel), 0);
      chk("rst_turncount", int'(bus_if.turnCount), 0);
      chk("rst_timeout", int'(bus_if.timeoutFlag), 0);
      chk("rst_vx", int'(bus_if.cueVelocityX), 0);
      chk("rst_vy", int'(bus_if.cueVelocityY), 0);
      chk("rst_pulses", we_cnt + halt_cnt + done_cnt, 0);
      resetN = 1'b1;
      @(posedge clk); #1;

      // Settle interrupted by one moving frame restarts the count
      repeat (5) frame(1'b0, ALL);
      frame(1'b0, 4'($urandom_range(0, 14)));
      settle_to_aim(1'b0);

      // Motion in AIM wins over a press
      frame(1'b0, ALL);
      frame(1'b1, 4'b1011);
      chk("aim_motion_prio", int'(bus_if.aimReady), 0);
      chk("aim_motion_power", int'(bus_if.powerLevel), 0);
      settle_to_aim(1'b0);

      // Directed first turn
      arm();
      charge(10);
      release_shot(64, -32);
      roll(2);

      // Button held over turn end is ignored; then saturation and clamping
      settle_to_aim(1'b1);
      repeat (3) frame(1'b1, ALL);
      chk("held_ignored_power", int'(bus_if.powerLevel), 0);
      chk("held_ignored_aim", int'(bus_if.aimReady), 1);
      arm();
      charge(60);
      release_shot(100, -128);
      roll(0);

      // Zero-power release returns to AIM; then floor of negative velocity
      settle_to_aim(1'b0);
      arm();
      exp_pwr = 0;
      release_shot(5, 5);
      arm();
      charge(10);
      release_shot(-1, 0);
      roll(1);

      // Randomized turns
      for (int i = 0; i < 6; i++) begin
         ax = int'($urandom_range(0, 255)) - 128;
         ay = int'($urandom_range(0, 255)) - 128;
         n  = int'($urandom_range(1, 60));
         m  = int'($urandom_range(0, 4));
         settle_to_aim(1'b0);
         arm();
         charge(n);
         release_shot(ax, ay);
         roll(m);
      end

      // Timeout: ball 1 never stops
      settle_to_aim(1'b0);
      arm();
      charge(3);
      release_shot(int'($urandom_range(0, 128)) - 64, 17);
      frame(1'b0, 4'b1100);
      repeat (1799) frame(1'b0, 4'b1101);
      chk("timeout_not_yet", halt_cnt, exp_halt);
      frame(1'b0, 4'b1101);
      exp_halt++;
      exp_done++;
      exp_turns = (exp_turns + 1) % 256;
      exp_timeout = 1;
      chk("halt_count", halt_cnt, exp_halt);
      chk("halt_latency", halt_cyc, fc + 1);
      chk("halt_done_latency", done_cyc, fc + 2);
      chk("halt_done_count", done_cnt, exp_done);
      chk("halt_timeout_flag", int'(bus_if.timeoutFlag), 1);
      chk("halt_turncount", int'(bus_if.turnCount), exp_turns);

      // All-stopped on the timeout frame wins; strike clears timeoutFlag
      settle_to_aim(1'b0);
      chk("timeout_sticky", int'(bus_if.timeoutFlag), 1);
      arm();
      charge(2);
      release_shot(-40, 64);
      frame(1'b0, 4'b1100);
      repeat (1799) frame(1'b0, 4'b1101);
      frame(1'b0, ALL);
      end_turn_checks();

      // Reset in the middle of a charge
      settle_to_aim(1'b0);
      arm();
      charge(5);
      resetN = 1'b0;
      @(posedge clk); #1;
      exp_turns = 0; exp_vx = 0; exp_vy = 0; exp_pwr = 0; exp_timeout = 0;
      chk("midrst_power", int'(bus_if.powerLevel), 0);
      chk("midrst_aimready", int'(bus_if.aimReady), 0);
      chk("midrst_turncount", int'(bus_if.turnCount), 0);
      chk("midrst_vx", int'(bus_if.cueVelocityX), 0);
      @(posedge clk); #1 resetN = 1'b1;
      settle_to_aim(1'b0);
      chk("midrst_no_strike", we_cnt, exp_we);
      chk("midrst_no_halt", halt_cnt, exp_halt);

      chk("pulse_overlap", viol_cnt, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
